tmr_scrub_controller: RTL

Sequencer that periodically sweeps a bank of triplicated registers, reads all three copies of each register, majority-votes them, and writes the voted value back whenever any copy disagrees. This repairs accumulated single-copy upsets before a second upset can corrupt the vote. It sits beside the triplicated storage as its only scrub-path master and exports an error count for monitoring.

---
 rtl/tmr_scrub_pkg.sv | 16 +
 rtl/scrub_vote.sv | 20 ++
 rtl/tmr_scrub_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tmr_scrub_pkg.sv
// Shared types and the voting primitive for the TMR scrub path.
package tmr_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    WRITE
  } scrub_state_e;

  // Two-of-three majority on a single bit; applied bitwise by scrub_vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/scrub_vote.sv
// Bitwise majority of three register copies plus a flag raised when any copy
// disagrees with the voted value.
module scrub_vote #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic             mismatch
);
  import tmr_scrub_pkg::*;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign voted[i] = maj3(a[i], b[i], c[i]);
  end

  assign mismatch = (a != voted) | (b != voted) | (c != voted);

endmodule

// File: rtl/tmr_scrub_controller.sv
// Periodic scrubber for a bank of triplicated registers: read, vote, and
// write back the voted value whenever any copy disagrees.
(* dont_triplicate = "true" *)
module tmr_scrub_controller #(
  parameter int NREG   = 8,
  parameter int WIDTH  = 8,
  parameter int PERIOD = 256,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    force_scrub,
  output logic [$clog2(NREG)-1:0] addr,
  output logic                    rd_en,
  input  logic [WIDTH-1:0]        rd_a,
  input  logic [WIDTH-1:0]        rd_b,
  input  logic [WIDTH-1:0]        rd_c,
  output logic                    wr_en,
  output logic [WIDTH-1:0]        wr_data,
  output logic                    busy,
  output logic                    sweep_done,
  output logic [CNT_W-1:0]        err_count,
  output logic [$clog2(NREG)-1:0] last_err_addr
);
  import tmr_scrub_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam int TW = $clog2(PERIOD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(PERIOD - 1);

  scrub_state_e     state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    last_err_addr_q, last_err_addr_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             sweep_done_q, sweep_done_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] voted;
  logic             mismatch;
  logic             advance;

  scrub_vote #(.WIDTH(WIDTH)) u_vote (
    .a       (rd_a),
    .b       (rd_b),
    .c       (rd_c),
    .voted   (voted),
    .mismatch(mismatch)
  );

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    addr_d          = addr_q;
    last_err_addr_d = last_err_addr_q;
    wr_data_d       = wr_data_q;
    err_count_d     = err_count_q;
    busy_d          = busy_q;
    rd_en_d         = 1'b0;
    wr_en_d         = 1'b0;
    sweep_done_d    = 1'b0;
    advance         = 1'b0;

    case (state_q)
      IDLE: begin
        if ((enable && timer_q == TIMER_END) || force_scrub) begin
          state_d = READ;
          addr_d  = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end else if (enable) begin
          timer_d = timer_q + TW'(1);
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        // Read data is only valid in this cycle, so the vote is captured here.
        if (mismatch) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_data_d = voted;
        end else begin
          advance = 1'b1;
        end
      end
      WRITE: begin
        advance         = 1'b1;
        last_err_addr_d = addr_q;
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        state_d      = IDLE;
        addr_d       = '0;
        timer_d      = '0;
        busy_d       = 1'b0;
        sweep_done_d = 1'b1;
      end else begin
        state_d = READ;
        addr_d  = addr_q + AW'(1);
        rd_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      addr_q          <= '0;
      last_err_addr_q <= '0;
      rd_en_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      busy_q          <= 1'b0;
      sweep_done_q    <= 1'b0;
      wr_data_q       <= '0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      addr_q          <= addr_d;
      last_err_addr_q <= last_err_addr_d;
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      busy_q          <= busy_d;
      sweep_done_q    <= sweep_done_d;
      wr_data_q       <= wr_data_d;
      err_count_q     <= err_count_d;
    end
  end

  assign addr          = addr_q;
  assign rd_en         = rd_en_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign sweep_done    = sweep_done_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;

endmodule
